// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1xN stream demultiplexer.
package demux_pkg;

  localparam int unsigned DROP_W_DEFAULT = 8;
  localparam int unsigned DROP_MAX       = (1 << DROP_W_DEFAULT) - 1;

  // Select width that never collapses to zero bits (N_OUT = 2 still needs one bit).
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slice for a single demux channel.
module demux_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             can_take
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Load wins over drain so a beat leaving this cycle can be replaced without a bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign can_take  = ~valid_q | out_ready;

endmodule

// File: rtl/demux_stream_1xn.sv
// Valid/ready stream demux: routes each beat to one of N_OUT registered channels or broadcasts it.
module demux_stream_1xn
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned N_OUT  = 4,
  parameter int unsigned SEL_W  = clog2_min1(N_OUT),
  parameter int unsigned DROP_W = DROP_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic                   err_sel,
  output logic [DROP_W-1:0]      drop_cnt
);

  localparam int unsigned NCodes = 1 << SEL_W;

  logic [N_OUT-1:0]  can_take;
  logic [N_OUT-1:0]  load;
  logic [NCodes-1:0] code_take;
  logic [NCodes-1:0] code_ok;
  logic              fire;
  logic              drop;
  logic              err_q, err_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  // Unused select codes always accept so the producer never stalls on a bad index.
  for (genvar g = 0; g < NCodes; g++) begin : g_code
    if (g < N_OUT) begin : g_in
      assign code_take[g] = can_take[g];
      assign code_ok[g]   = 1'b1;
    end else begin : g_out
      assign code_take[g] = 1'b1;
      assign code_ok[g]   = 1'b0;
    end
  end

  assign in_ready = rst_n & (in_bcast ? &can_take : code_take[in_sel]);
  assign fire     = in_valid & in_ready;
  assign drop     = fire & ~in_bcast & ~code_ok[in_sel];

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign load[k] = fire & (in_bcast | (in_sel == SEL_W'(k)));

    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*WIDTH +: WIDTH]),
      .can_take  (can_take[k])
    );
  end

  always_comb begin
    err_d      = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && !(&drop_cnt_q)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign err_sel  = err_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Scoreboard bench: a 4-channel instance for routing/back-pressure, a 3-channel one for drops.
module tb_demux_stream_1xn;

  logic        clk;
  logic        rst_n;

  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        err_sel;
  logic [7:0]  drop_cnt;

  logic [7:0]  in_data3;
  logic [1:0]  in_sel3;
  logic        in_bcast3;
  logic        in_valid3;
  logic        in_ready3;
  logic [23:0] out_data3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic        err_sel3;
  logic [7:0]  drop_cnt3;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0]  sbq [4][$];
  logic        exp_err3;
  logic [7:0]  exp_drop3;

  demux_stream_1xn #(
    .WIDTH  (8),
    .N_OUT  (4),
    .DROP_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_sel   (err_sel),
    .drop_cnt  (drop_cnt)
  );

  demux_stream_1xn #(
    .WIDTH  (8),
    .N_OUT  (3),
    .DROP_W (8)
  ) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_sel    (in_sel3),
    .in_bcast  (in_bcast3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .err_sel   (err_sel3),
    .drop_cnt  (drop_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard for the 4-channel instance; each queue models one channel's slot.
  always @(negedge clk) begin : mon
    logic [3:0] take;
    logic       exp_rdy;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) sbq[k].delete();
      check("rst_in_ready", 32'(in_ready), 32'd0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(sbq[k].size() != 0));
        if (out_valid[k] && sbq[k].size() != 0)
          check($sformatf("out_data%0d", k), 32'(out_data[k*8 +: 8]), 32'(sbq[k][0]));
        take[k] = (sbq[k].size() == 0) || out_ready[k];
      end
      exp_rdy = in_bcast ? &take : take[in_sel];
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("err_sel", 32'(err_sel), 32'd0);
      check("drop_cnt", 32'(drop_cnt), 32'd0);
      for (int k = 0; k < 4; k++)
        if (out_valid[k] && out_ready[k] && sbq[k].size() != 0) void'(sbq[k].pop_front());
      if (in_valid && in_ready) begin
        if (in_bcast) begin
          for (int k = 0; k < 4; k++) sbq[k].push_back(in_data);
        end else begin
          sbq[in_sel].push_back(in_data);
        end
      end
    end
  end

  // Drop-path model for the 3-channel instance.
  always @(negedge clk) begin : mon3
    logic oob_fire;
    if (!rst_n) begin
      exp_err3  = 1'b0;
      exp_drop3 = 8'd0;
      check("rst_drop3", 32'(drop_cnt3), 32'd0);
    end else begin
      check("err_sel3", 32'(err_sel3), 32'(exp_err3));
      check("drop_cnt3", 32'(drop_cnt3), 32'(exp_drop3));
      check("out_valid3", 32'(out_valid3), 32'd0);
      check("in_ready3", 32'(in_ready3), 32'd1);
      oob_fire = in_valid3 && in_ready3 && !in_bcast3 && (in_sel3 >= 2'd3);
      exp_err3 = oob_fire;
      if (oob_fire && exp_drop3 != 8'hFF) exp_drop3 = exp_drop3 + 8'd1;
    end
  end

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [1:0] sel, input logic [7:0] d, input logic bc);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    in_bcast = bc;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    in_bcast = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n      = 1'b0;
    in_data    = 8'h00;
    in_sel     = 2'd0;
    in_bcast   = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 4'b1111;
    in_data3   = 8'hE5;
    in_sel3    = 2'd3;
    in_bcast3  = 1'b0;
    in_valid3  = 1'b0;
    out_ready3 = 3'b111;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_err_sel", 32'(err_sel), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Unicast sweep
    for (int k = 0; k < 4; k++) send(2'(k), 8'hA0 + 8'(k), 1'b0);
    idle(2);

    // Back-pressure on channel 2, channel 1 unaffected
    out_ready = 4'b1011;
    send(2'd2, 8'h11, 1'b0);
    send(2'd1, 8'h33, 1'b0);
    in_valid = 1'b1;
    in_sel   = 2'd2;
    in_data  = 8'h22;
    repeat (3) begin
      @(negedge clk);
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_hold", 32'(out_data[23:16]), 32'h11);
    end
    @(posedge clk);
    #1 out_ready = 4'b1111;
    send(2'd2, 8'h22, 1'b0);
    idle(2);

    // Broadcast blocked by one full slot
    out_ready = 4'b1011;
    send(2'd2, 8'h44, 1'b0);
    in_valid = 1'b1;
    in_bcast = 1'b1;
    in_sel   = 2'd0;
    in_data  = 8'h5A;
    repeat (2) begin
      @(negedge clk);
      check("bcast_blocked", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 4'b1111;
    send(2'd0, 8'h5A, 1'b1);
    @(negedge clk);
    check("bcast_valid", 32'(out_valid), 32'hF);
    check("bcast_data", out_data, 32'h5A5A5A5A);
    @(posedge clk);
    #1;
    idle(2);

    // Drain and reload in the same cycle
    send(2'd0, 8'h66, 1'b0);
    send(2'd0, 8'h77, 1'b0);
    @(negedge clk);
    check("reload_valid", 32'(out_valid[0]), 32'd1);
    check("reload_data", 32'(out_data[7:0]), 32'h77);
    @(posedge clk);
    #1;
    idle(2);

    // Out-of-range select on the 3-channel instance
    in_valid3 = 1'b1;
    repeat (300) @(posedge clk);
    #1 in_valid3 = 1'b0;
    @(negedge clk);
    check("drop_sat", 32'(drop_cnt3), 32'(demux_pkg::DROP_MAX));
    @(posedge clk);
    #1;

    // Async reset with all slots full
    out_ready = 4'b0000;
    send(2'd0, 8'hC3, 1'b1);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_drop3", 32'(drop_cnt3), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 4'b1111;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
